alu_rs_scheduler: RTL and testbench

Reservation station and issue scheduler for the out-of-order core's integer ALU. It holds decoded ALU, branch and jump instructions between dispatch and execution, tracks operand readiness by ROB tag, and snoops the ALU and LSB result buses for wakeup. It issues at most one ready instruction per cycle to the ALU and is flushed on rollback.

---
 rtl/alu_rs_scheduler_pkg.sv | 20 ++
 rtl/alu_rs_select.sv | 23 ++
 rtl/alu_rs_scheduler.sv | 163 ++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared types for the integer ALU reservation station: decoded-op fields and opcode map.
package alu_rs_scheduler_pkg;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7;
  } alu_op_t;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;
endpackage

// File: rtl/alu_rs_select.sv
// Priority encoders over the station: lowest free slot and lowest issue-ready slot.
module alu_rs_select #(
  parameter int RS_SIZE = 16,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input  logic [RS_SIZE-1:0] busy,
  input  logic [RS_SIZE-1:0] ready,
  output logic [IDX_W-1:0]   free_idx,
  output logic               has_free,
  output logic [IDX_W-1:0]   ready_idx,
  output logic               has_ready
);
  always_comb begin
    free_idx  = '0;
    ready_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i])  free_idx  = IDX_W'(i);
      if (ready[i])  ready_idx = IDX_W'(i);
    end
    has_free  = ~&busy;
    has_ready = |ready;
  end
endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds dispatched ops, snoops ALU/LSB CDBs, issues one ready op per cycle.
// Optional same-cycle dispatch-to-issue path enabled by defining ALU_RS_ISSUE_BYPASS_EN.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE   = 16,
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 disp_en,
  input  logic [6:0]           disp_opcode,
  input  logic [2:0]           disp_funct3,
  input  logic                 disp_funct7,
  input  logic                 disp_q1_rdy,
  input  logic                 disp_q2_rdy,
  input  logic [DATA_W-1:0]    disp_v1,
  input  logic [DATA_W-1:0]    disp_v2,
  input  logic [ROB_POS_W-1:0] disp_q1,
  input  logic [ROB_POS_W-1:0] disp_q2,
  input  logic [DATA_W-1:0]    disp_imm,
  input  logic [DATA_W-1:0]    disp_pc,
  input  logic [ROB_POS_W-1:0] disp_rob_pos,
  output logic                 full,
  input  logic                 alu_cdb_en,
  input  logic [ROB_POS_W-1:0] alu_cdb_pos,
  input  logic [DATA_W-1:0]    alu_cdb_val,
  input  logic                 lsb_cdb_en,
  input  logic [ROB_POS_W-1:0] lsb_cdb_pos,
  input  logic [DATA_W-1:0]    lsb_cdb_val,
  output logic                 alu_en,
  output logic [6:0]           alu_opcode,
  output logic [2:0]           alu_funct3,
  output logic                 alu_funct7,
  output logic [DATA_W-1:0]    alu_val1,
  output logic [DATA_W-1:0]    alu_val2,
  output logic [DATA_W-1:0]    alu_imm,
  output logic [DATA_W-1:0]    alu_pc,
  output logic [ROB_POS_W-1:0] alu_rob_pos
);
  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    alu_op_t              op;
    logic                 r1;
    logic                 r2;
    logic [DATA_W-1:0]    v1;
    logic [DATA_W-1:0]    v2;
    logic [ROB_POS_W-1:0] q1;
    logic [ROB_POS_W-1:0] q2;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic [ROB_POS_W-1:0] rob_pos;
  } entry_t;

  entry_t               ent [RS_SIZE];
  logic [RS_SIZE-1:0]   busy, ready;
  logic [IDX_W-1:0]     free_idx, ready_idx;
  logic                 has_free, has_ready, bypass, issue, accept;
  entry_t               disp_ent, iss_ent;
  logic [DATA_W:0]      ds1, ds2;
  logic [DATA_W:0]      wk1 [RS_SIZE];
  logic [DATA_W:0]      wk2 [RS_SIZE];

  // {ready, value} after looking at both result buses; the buses never share a tag.
  function automatic logic [DATA_W:0] snoop(input logic r, input logic [DATA_W-1:0] v,
                                            input logic [ROB_POS_W-1:0] q);
    if (r)                                return {1'b1, v};
    else if (alu_cdb_en && alu_cdb_pos == q) return {1'b1, alu_cdb_val};
    else if (lsb_cdb_en && lsb_cdb_pos == q) return {1'b1, lsb_cdb_val};
    else                                  return {1'b0, v};
  endfunction

  always_comb begin
    ds1 = snoop(disp_q1_rdy, disp_v1, disp_q1);
    ds2 = snoop(disp_q2_rdy, disp_v2, disp_q2);
    disp_ent = '{op: '{opcode: disp_opcode, funct3: disp_funct3, funct7: disp_funct7},
                 r1: ds1[DATA_W], r2: ds2[DATA_W],
                 v1: ds1[DATA_W-1:0], v2: ds2[DATA_W-1:0],
                 q1: disp_q1, q2: disp_q2, imm: disp_imm, pc: disp_pc,
                 rob_pos: disp_rob_pos};
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] & ent[i].r1 & ent[i].r2;
      wk1[i]   = snoop(ent[i].r1, ent[i].v1, ent[i].q1);
      wk2[i]   = snoop(ent[i].r2, ent[i].v2, ent[i].q2);
    end
  end

  alu_rs_select #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) u_select (
    .busy     (busy),
    .ready    (ready),
    .free_idx (free_idx),
    .has_free (has_free),
    .ready_idx(ready_idx),
    .has_ready(has_ready)
  );

`ifdef ALU_RS_ISSUE_BYPASS_EN
  assign bypass = disp_en && has_free && !has_ready && disp_ent.r1 && disp_ent.r2;
`else
  assign bypass = 1'b0;
`endif

  assign full    = ~has_free;
  assign issue   = has_ready | bypass;
  assign accept  = disp_en && has_free && !bypass;
  assign iss_ent = has_ready ? ent[ready_idx] : disp_ent;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      if (rollback) begin
        busy   <= '0;
        alu_en <= 1'b0;
      end else begin
        alu_en <= issue;
        if (issue) begin
          alu_opcode  <= iss_ent.op.opcode;
          alu_funct3  <= iss_ent.op.funct3;
          alu_funct7  <= iss_ent.op.funct7;
          alu_val1    <= iss_ent.v1;
          alu_val2    <= iss_ent.v2;
          alu_imm     <= iss_ent.imm;
          alu_pc      <= iss_ent.pc;
          alu_rob_pos <= iss_ent.rob_pos;
        end
        // free_idx is never busy, so it cannot collide with ready_idx
        if (has_ready) busy[ready_idx] <= 1'b0;
        if (accept)    busy[free_idx]  <= 1'b1;
      end
    end
  end

  // Payload needs no reset: it is only observed while busy.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          ent[i].r1 <= wk1[i][DATA_W];
          ent[i].v1 <= wk1[i][DATA_W-1:0];
          ent[i].r2 <= wk2[i][DATA_W];
          ent[i].v2 <= wk2[i][DATA_W-1:0];
        end
      end
      if (accept) ent[free_idx] <= disp_ent;
    end
  end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios plus random traffic vs a slot-array model.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

`ifdef ALU_RS_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int N = 16;

  logic        clk = 0, rst, rdy, rollback, disp_en;
  logic [6:0]  disp_opcode;
  logic [2:0]  disp_funct3;
  logic        disp_funct7, disp_q1_rdy, disp_q2_rdy;
  logic [31:0] disp_v1, disp_v2, disp_imm, disp_pc;
  logic [3:0]  disp_q1, disp_q2, disp_rob_pos;
  logic        full;
  logic        alu_cdb_en, lsb_cdb_en;
  logic [3:0]  alu_cdb_pos, lsb_cdb_pos;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        alu_en, alu_funct7;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  alu_rs_scheduler #(.RS_SIZE(N), .ROB_POS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .disp_en(disp_en),
    .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
    .disp_q1_rdy(disp_q1_rdy), .disp_q2_rdy(disp_q2_rdy), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_imm(disp_imm), .disp_pc(disp_pc),
    .disp_rob_pos(disp_rob_pos), .full(full),
    .alu_cdb_en(alu_cdb_en), .alu_cdb_pos(alu_cdb_pos), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_en(lsb_cdb_en), .lsb_cdb_pos(lsb_cdb_pos), .lsb_cdb_val(lsb_cdb_val),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain table of slots, each holding an op waiting for two operands.
  bit          m_busy [N];
  bit          m_r1 [N], m_r2 [N];
  logic [31:0] m_v1 [N], m_v2 [N], m_imm [N], m_pc [N];
  logic [3:0]  m_q1 [N], m_q2 [N], m_rob [N];
  logic [6:0]  m_op [N];
  logic [2:0]  m_f3 [N];
  logic        m_f7 [N];
  logic        e_en, e_f7;
  logic [6:0]  e_op;
  logic [2:0]  e_f3;
  logic [31:0] e_v1, e_v2, e_imm, e_pc;
  logic [3:0]  e_rob;

  // Value of a tagged operand if one of the buses delivers it this cycle.
  function automatic bit bus_has(input logic [3:0] tag, output logic [31:0] val);
    val = 32'h0;
    if (alu_cdb_en && alu_cdb_pos == tag) begin val = alu_cdb_val; return 1; end
    if (lsb_cdb_en && lsb_cdb_pos == tag) begin val = lsb_cdb_val; return 1; end
    return 0;
  endfunction

  task automatic model_step();
    int sel, fr, cnt;
    bit d1, d2, byp;
    logic [31:0] dv1, dv2, bv;
    if (rst) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      e_en = 0; e_op = 0; e_f3 = 0; e_f7 = 0;
      e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
      return;
    end
    if (!rdy) return;
    if (rollback) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      e_en = 0;
      return;
    end
    sel = -1; fr = -1; cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && m_r1[i] && m_r2[i] && sel < 0) sel = i;
      if (!m_busy[i] && fr < 0) fr = i;
      cnt += m_busy[i];
    end
    d1 = disp_q1_rdy; dv1 = disp_v1;
    d2 = disp_q2_rdy; dv2 = disp_v2;
    if (!d1 && bus_has(disp_q1, bv)) begin d1 = 1; dv1 = bv; end
    if (!d2 && bus_has(disp_q2, bv)) begin d2 = 1; dv2 = bv; end
    byp = BYP && disp_en && cnt < N && sel < 0 && d1 && d2;
    for (int i = 0; i < N; i++) begin
      if (!m_busy[i]) continue;
      if (!m_r1[i] && bus_has(m_q1[i], bv)) begin m_r1[i] = 1; m_v1[i] = bv; end
      if (!m_r2[i] && bus_has(m_q2[i], bv)) begin m_r2[i] = 1; m_v2[i] = bv; end
    end
    if (sel >= 0) begin
      e_en = 1; e_op = m_op[sel]; e_f3 = m_f3[sel]; e_f7 = m_f7[sel];
      e_v1 = m_v1[sel]; e_v2 = m_v2[sel]; e_imm = m_imm[sel]; e_pc = m_pc[sel]; e_rob = m_rob[sel];
      m_busy[sel] = 0;
    end else if (byp) begin
      e_en = 1; e_op = disp_opcode; e_f3 = disp_funct3; e_f7 = disp_funct7;
      e_v1 = dv1; e_v2 = dv2; e_imm = disp_imm; e_pc = disp_pc; e_rob = disp_rob_pos;
    end else begin
      e_en = 0;
    end
    if (disp_en && cnt < N && !byp) begin
      m_busy[fr] = 1; m_r1[fr] = d1; m_r2[fr] = d2; m_v1[fr] = dv1; m_v2[fr] = dv2;
      m_q1[fr] = disp_q1; m_q2[fr] = disp_q2; m_imm[fr] = disp_imm; m_pc[fr] = disp_pc;
      m_rob[fr] = disp_rob_pos; m_op[fr] = disp_opcode; m_f3[fr] = disp_funct3; m_f7[fr] = disp_funct7;
    end
  endtask

  task automatic compare();
    int cnt = 0;
    foreach (m_busy[i]) cnt += m_busy[i];
    chk("full", 32'(full), 32'(cnt == N));
    chk("alu_en", 32'(alu_en), 32'(e_en));
    chk("alu_opcode", 32'(alu_opcode), 32'(e_op));
    chk("alu_funct3", 32'(alu_funct3), 32'(e_f3));
    chk("alu_funct7", 32'(alu_funct7), 32'(e_f7));
    chk("alu_val1", alu_val1, e_v1);
    chk("alu_val2", alu_val2, e_v2);
    chk("alu_imm", alu_imm, e_imm);
    chk("alu_pc", alu_pc, e_pc);
    chk("alu_rob_pos", 32'(alu_rob_pos), 32'(e_rob));
  endtask

  // Inputs are applied after a negedge; the model advances, then outputs are checked at the next negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    rst = 0; rdy = 1; rollback = 0; disp_en = 0; alu_cdb_en = 0; lsb_cdb_en = 0;
  endtask

  task automatic disp(input logic [6:0] op, input bit r1, input logic [31:0] v1, input logic [3:0] q1,
                      input bit r2, input logic [31:0] v2, input logic [3:0] q2,
                      input logic [31:0] imm, input logic [3:0] rob);
    disp_en = 1; disp_opcode = op; disp_funct3 = 3'($urandom); disp_funct7 = 1'($urandom);
    disp_q1_rdy = r1; disp_v1 = v1; disp_q1 = q1;
    disp_q2_rdy = r2; disp_v2 = v2; disp_q2 = q2;
    disp_imm = imm; disp_pc = $urandom; disp_rob_pos = rob;
  endtask

  task automatic cdb_alu(input logic [3:0] pos, input logic [31:0] val);
    alu_cdb_en = 1; alu_cdb_pos = pos; alu_cdb_val = val;
  endtask

  initial begin
    idle();
    rst = 1;
    disp_opcode = 0; disp_funct3 = 0; disp_funct7 = 0; disp_q1_rdy = 0; disp_q2_rdy = 0;
    disp_v1 = 0; disp_v2 = 0; disp_q1 = 0; disp_q2 = 0; disp_imm = 0; disp_pc = 0; disp_rob_pos = 0;
    alu_cdb_pos = 0; alu_cdb_val = 0; lsb_cdb_pos = 0; lsb_cdb_val = 0;
    @(negedge clk);
    tick(); tick();
    chk("reset_alu_en", 32'(alu_en), 32'd0);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_val1", alu_val1, 32'd0);
    idle();

    // ADDI with both operands ready
    disp(OP_IMM, 1, 32'd5, 4'd0, 1, 32'd0, 4'd0, 32'd7, 4'd3);
    tick();
`ifdef ALU_RS_ISSUE_BYPASS_EN
    chk("addi_byp_en", 32'(alu_en), 32'd1);
    chk("addi_byp_val1", alu_val1, 32'd5);
`else
    chk("addi_hold_en", 32'(alu_en), 32'd0);
`endif
    idle(); tick();
`ifndef ALU_RS_ISSUE_BYPASS_EN
    chk("addi_en", 32'(alu_en), 32'd1);
    chk("addi_val1", alu_val1, 32'd5);
    chk("addi_imm", alu_imm, 32'd7);
    chk("addi_rob", 32'(alu_rob_pos), 32'd3);
`endif

    // ADD waiting on tag 6 from the ALU bus
    disp(OP_REG, 1, 32'd1, 4'd0, 0, 32'd0, 4'd6, 32'd0, 4'd5);
    tick(); idle();
    cdb_alu(4'd6, 32'h10);
    tick();
    chk("add_wait_en", 32'(alu_en), 32'd0);
    idle(); tick();
    chk("add_en", 32'(alu_en), 32'd1);
    chk("add_val2", alu_val2, 32'h10);

    // Operand captured from the LSB bus at dispatch
    disp(OP_BRANCH, 0, 32'd0, 4'd2, 1, 32'd4, 4'd0, 32'd8, 4'd7);
    lsb_cdb_en = 1; lsb_cdb_pos = 4'd2; lsb_cdb_val = 32'd9;
    tick(); idle(); tick();
`ifndef ALU_RS_ISSUE_BYPASS_EN
    chk("lsbcap_en", 32'(alu_en), 32'd1);
    chk("lsbcap_val1", alu_val1, 32'd9);
`endif

    // Fill the station, reject an extra dispatch, then wake slot 4
    for (int i = 0; i < N; i++) begin
      disp(OP_REG, 0, 32'd0, 4'(i), 1, 32'(i), 4'd0, 32'(i), 4'(i));
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    disp(OP_IMM, 1, 32'hAA, 4'd0, 1, 32'hBB, 4'd0, 32'd0, 4'd9);
    tick();
    chk("full_reject_en", 32'(alu_en), 32'd0);
    chk("full_still", 32'(full), 32'd1);
    idle(); cdb_alu(4'd4, 32'h44);
    tick(); idle(); tick();
    chk("wake4_en", 32'(alu_en), 32'd1);
    chk("wake4_rob", 32'(alu_rob_pos), 32'd4);
    chk("wake4_val1", alu_val1, 32'h44);
    chk("wake4_full", 32'(full), 32'd0);
    rollback = 1; tick(); idle();

    // Rollback beats an issue made possible by an earlier wakeup
    for (int i = 0; i < 5; i++) begin
      disp(OP_JALR, 0, 32'd0, 4'(10 + i), 1, 32'd0, 4'd0, 32'd0, 4'(i));
      tick();
    end
    idle(); cdb_alu(4'd10, 32'h77); tick();
    idle(); rollback = 1; tick();
    chk("rb_en", 32'(alu_en), 32'd0);
    chk("rb_full", 32'(full), 32'd0);
    idle(); tick();
    chk("rb_after_en", 32'(alu_en), 32'd0);

    // rdy low freezes issue and wakeup
    disp(OP_REG, 0, 32'd0, 4'd7, 1, 32'd2, 4'd0, 32'd0, 4'd11);
    tick();
    disp(OP_IMM, 1, 32'd3, 4'd0, 1, 32'd0, 4'd0, 32'd1, 4'd12);
    tick();
    idle(); rdy = 0; cdb_alu(4'd7, 32'h99);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_en", 32'(alu_en), 32'(BYP));
    end
    idle(); tick();
`ifndef ALU_RS_ISSUE_BYPASS_EN
    chk("thaw_en", 32'(alu_en), 32'd1);
    chk("thaw_rob", 32'(alu_rob_pos), 32'd12);
`endif
    tick();
    chk("no_wake_en", 32'(alu_en), 32'd0);
    rollback = 1; tick(); idle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1)
        disp(7'($urandom), 1'($urandom), $urandom, 4'($urandom), 1'($urandom), $urandom,
             4'($urandom), $urandom, 4'($urandom));
      else
        disp_en = 0;
      alu_cdb_en = ($urandom_range(0, 9) < 4); alu_cdb_pos = 4'($urandom); alu_cdb_val = $urandom;
      lsb_cdb_en = ($urandom_range(0, 9) < 3); lsb_cdb_pos = 4'($urandom); lsb_cdb_val = $urandom;
      if (alu_cdb_en && lsb_cdb_en && alu_cdb_pos == lsb_cdb_pos) lsb_cdb_en = 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
